// File: rtl/mux_scan_scheduler_if.sv
// ADC conversion handshake and tagged sample output of the mux scan scheduler.
// The master side is the scheduler; the slave side is the ADC front end and sample sink.
interface mux_scan_scheduler_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [4:0]        sample_addr;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data,
        output sample_valid,
        output sample_data,
        output sample_addr
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data,
        input  sample_valid,
        input  sample_data,
        input  sample_addr
    );
endinterface

// File: rtl/mux_scan_scheduler.sv
// Settle-aware frame scheduler: one calibration slot plus 16 channels,
// one handshaked ADC conversion per slot, tagged sample out.
module mux_scan_scheduler #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_W         = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_start,
    mux_scan_scheduler_if.master adc_if,
    output logic [2:0]           mx_a3,
    output logic [2:0]           mx_a12,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SET_MUX,
        SETTLE,
        CONVERT,
        WAIT_DONE,
        STORE,
        NEXT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [4:0]        slot;
    logic [1:0]        calib_idx;
    logic [SW-1:0]     settle_cnt;
    logic [TW-1:0]     to_cnt;
    logic [DATA_W-1:0] cap_data;
    logic [2:0]        cal_sel;
    logic              last_slot;
    logic              to_hit;

    assign last_slot = (slot == 5'd16);
    assign to_hit    = (to_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        cal_sel = 3'd5;
        unique case (calib_idx)
            2'd0: cal_sel = 3'd5;
            2'd1: cal_sel = 3'd3;
            2'd2: cal_sel = 3'd5;
            2'd3: cal_sel = 3'd2;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (frame_start && enable) state_n = SET_MUX;
            SET_MUX:   state_n = SETTLE;
            SETTLE:    if (settle_cnt == '0) state_n = CONVERT;
            CONVERT:   state_n = WAIT_DONE;
            WAIT_DONE: if (adc_if.adc_done || to_hit) state_n = STORE;
            STORE:     state_n = NEXT;
            NEXT:      state_n = (last_slot || !enable) ? IDLE : SET_MUX;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        adc_if.adc_start    = (state == CONVERT);
        adc_if.sample_valid = (state == STORE);
        adc_if.sample_data  = (state == STORE) ? cap_data : '0;
        adc_if.sample_addr  = (state == STORE) ? slot : '0;
        frame_done          = (state == NEXT) && last_slot;
        busy                = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot        <= '0;
            calib_idx   <= '0;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            cap_data    <= '0;
            mx_a3       <= '0;
            mx_a12      <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start && enable) slot <= '0;
                end
                SET_MUX: begin
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                    // slots 1..8 and 9..16 share the low-3-bit decode
                    if (slot == 5'd0) begin
                        mx_a3 <= cal_sel;
                    end else begin
                        mx_a3  <= {2'b00, slot > 5'd8};
                        mx_a12 <= slot[2:0] - 3'd1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
                CONVERT: begin
                    to_cnt <= '0;
                end
                WAIT_DONE: begin
                    if (adc_if.adc_done) begin
                        cap_data <= adc_if.adc_data;
                    end else if (to_hit) begin
                        cap_data    <= '1;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                STORE: begin
                end
                NEXT: begin
                    if (last_slot) begin
                        slot      <= '0;
                        calib_idx <= calib_idx + 2'd1;
                    end else if (!enable) begin
                        slot <= '0;
                    end else begin
                        slot <= slot + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_scheduler.sv
// Scoreboard bench for mux_scan_scheduler: ADC model pushes expected
// samples, the sample monitor pops and compares them.
module tb_mux_scan_scheduler;

    localparam int DW     = 12;
    localparam int SETTLE = 16;
    localparam int TMO    = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] mx_a3;
    logic [2:0] mx_a12;
    logic       frame_done;
    logic       busy;
    logic       timeout_err;

    mux_scan_scheduler_if #(.DATA_W(DW)) adc_if ();

    mux_scan_scheduler #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .DATA_W        (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_start(frame_start),
        .adc_if     (adc_if.master),
        .mx_a3      (mx_a3),
        .mx_a12     (mx_a12),
        .frame_done (frame_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int start;
        int span;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc = 0;
    int   exp_slot = 0;
    int   exp_cal = 0;
    int   adc_delay = 2;
    int   coinc_slot = -1;
    int   silent_slot = -1;
    int   abort_slot = -1;
    int   samp_cnt = 0;
    int   fd_cnt = 0;
    int   last_chg = 0;
    logic [5:0] prev_mx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int cal_tab(input int i);
        case (i)
            0:       return 5;
            1:       return 3;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    // ADC model, mux and settle checker
    initial begin
        int s;
        int d;
        int st;
        adc_if.adc_done = 1'b0;
        adc_if.adc_data = '0;
        forever begin
            @(negedge clk);
            if ({mx_a3, mx_a12} != prev_mx) begin
                prev_mx  = {mx_a3, mx_a12};
                last_chg = cyc;
            end
            if (adc_if.adc_start === 1'b1) begin
                s  = exp_slot;
                st = cyc;
                chk("settle", cyc - last_chg, SETTLE);
                if (s == 0) begin
                    chk("cal_a3", mx_a3, cal_tab(exp_cal));
                end else begin
                    chk("mx_a3", mx_a3, (s > 8) ? 1 : 0);
                    chk("mx_a12", mx_a12, (s > 8) ? s - 9 : s - 1);
                end
                exp_slot++;
                d = (s == coinc_slot) ? TMO + 1 : adc_delay;
                if (s == silent_slot) begin
                    sb.push_back('{s, 'hFFF, st, TMO + 2});
                end else begin
                    @(negedge clk);
                    if (s == abort_slot) enable = 1'b0;
                    repeat (d - 1) @(negedge clk);
                    adc_if.adc_done = 1'b1;
                    adc_if.adc_data = DW'(32'h100 + s);
                    sb.push_back('{s, 'h100 + s, st, d + 1});
                    @(negedge clk);
                    adc_if.adc_done = 1'b0;
                    adc_if.adc_data = '0;
                end
            end
        end
    end

    // sample monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (adc_if.sample_valid === 1'b1) begin
                samp_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("addr", adc_if.sample_addr, e.addr);
                    chk("data", adc_if.sample_data, e.data);
                    chk("span", cyc - e.start, e.span);
                end
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_frame(input bit mid);
        samp_cnt    = 0;
        fd_cnt      = 0;
        exp_slot    = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (mid) begin
            repeat (100) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic chk_full(input string tag);
        chk({tag, "_samples"}, samp_cnt, 17);
        chk({tag, "_frame_done"}, fd_cnt, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sb_left"}, sb.size(), 0);
        exp_cal = (exp_cal + 1) % 4;
    endtask

    function automatic logic [31:0] outs();
        return {4'b0, adc_if.adc_start, adc_if.sample_valid, adc_if.sample_data,
                adc_if.sample_addr, mx_a3, mx_a12, frame_done, busy, timeout_err};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 0);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 5; f++) begin
            run_frame(1'b0);
            chk_full("frame");
        end
        chk("to_err_clean", timeout_err, 0);

        coinc_slot = 3;
        run_frame(1'b0);
        coinc_slot = -1;
        chk_full("coinc");
        chk("to_err_coinc", timeout_err, 0);

        run_frame(1'b1);
        chk_full("mid_start");
        repeat (20) @(negedge clk);
        chk("no_requeue", busy, 0);

        abort_slot = 7;
        run_frame(1'b0);
        abort_slot = -1;
        chk("abort_samples", samp_cnt, 8);
        chk("abort_frame_done", fd_cnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sb_left", sb.size(), 0);
        enable = 1'b1;
        @(negedge clk);
        run_frame(1'b0);
        chk_full("after_abort");

        silent_slot = 5;
        run_frame(1'b0);
        silent_slot = -1;
        chk_full("timeout");
        chk("to_err_set", timeout_err, 1);
        run_frame(1'b0);
        chk_full("post_timeout");
        chk("to_err_sticky", timeout_err, 1);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("settle_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 0);
        exp_slot = 0;
        exp_cal  = 0;
        samp_cnt = 0;
        fd_cnt   = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_samples", samp_cnt, 0);
        chk("post_reset_frame_done", fd_cnt, 0);
        chk("post_reset_busy", busy, 0);
        run_frame(1'b0);
        chk_full("post_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
